// File: rtl/vc_fifo_if.sv
// Handshake bundle for the virtual-channel input buffer: shared write port, per-VC FWFT read ports.
// Latency and backpressure are defined by vc_fifo; this file only groups the wires.
// master = router-side producer/consumer, slave = the buffer itself.
interface vc_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_VC     = 2
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic                             in_valid;
    logic [VC_W-1:0]                  in_vc;
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             in_ready;
    logic [NUM_VC-1:0]                out_valid;
    logic [NUM_VC*DATA_WIDTH-1:0]     out_data;
    logic [NUM_VC-1:0]                out_ready;
    logic [NUM_VC-1:0]                full;
    logic [NUM_VC-1:0]                afull;
    logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count;
    logic                             err_clr;
    logic [NUM_VC-1:0]                err_ovf;
    logic [NUM_VC-1:0]                err_udf;

    modport master (
        output in_valid, in_vc, in_data, out_ready, err_clr,
        input  in_ready, out_valid, out_data, full, afull, count, err_ovf, err_udf
    );

    modport slave (
        input  in_valid, in_vc, in_data, out_ready, err_clr,
        output in_ready, out_valid, out_data, full, afull, count, err_ovf, err_udf
    );
endinterface

// File: rtl/vc_fifo.sv
// NUM_VC circular FWFT FIFOs behind one VC-steered write port; sticky error flags under VC_FIFO_ERR_EN.
// Latency: write visible at the head one cycle after the edge, no bypass from in_data.
// Backpressure: in_ready drops when the addressed VC is full or the tag is out of range.
module vc_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 2,
    parameter int NUM_VC       = 2,
    parameter int AFULL_THRESH = 3
) (
    input  logic       clk,
    input  logic       rst,
    vc_fifo_if.slave   bus
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   AF_L     = PW'(AFULL_THRESH);
    localparam logic [VC_W:0]   NUM_VC_L = (VC_W + 1)'(NUM_VC);

    logic [PW-1:0]         wr_ptr_q [NUM_VC];
    logic [PW-1:0]         wr_ptr_d [NUM_VC];
    logic [PW-1:0]         rd_ptr_q [NUM_VC];
    logic [PW-1:0]         rd_ptr_d [NUM_VC];
    logic [DATA_WIDTH-1:0] mem_q    [NUM_VC][DEPTH];

    logic [PW-1:0]         cnt_w    [NUM_VC];
    logic [NUM_VC-1:0]     full_w;
    logic [NUM_VC-1:0]     empty_w;
    logic [NUM_VC-1:0]     afull_w;
    logic [NUM_VC-1:0]     push_w;
    logic [NUM_VC-1:0]     pop_w;
    logic                  vc_ok;
    logic                  sel_full;
    logic                  in_ready_w;
    logic [NUM_VC*DATA_WIDTH-1:0] out_data_w;
    logic [NUM_VC*PW-1:0]  count_w;

    // Status is derived only from registered pointers, so every flag is 0 in reset.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            cnt_w[v]   = wr_ptr_q[v] - rd_ptr_q[v];
            empty_w[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
            full_w[v]  = (wr_ptr_q[v][PW-1] != rd_ptr_q[v][PW-1]) &&
                         (wr_ptr_q[v][ADDR_WIDTH-1:0] == rd_ptr_q[v][ADDR_WIDTH-1:0]);
            afull_w[v] = (cnt_w[v] >= AF_L);
        end
    end

    // in_ready looks at the pre-edge pointers, so a pop cannot make room for a same-cycle write.
    always_comb begin
        vc_ok    = ({1'b0, bus.in_vc} < NUM_VC_L);
        sel_full = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (bus.in_vc == VC_W'(v)) sel_full = full_w[v];
        end
        in_ready_w = vc_ok && !sel_full;
        for (int v = 0; v < NUM_VC; v++) begin
            push_w[v]   = bus.in_valid && in_ready_w && (bus.in_vc == VC_W'(v));
            pop_w[v]    = !empty_w[v] && bus.out_ready[v];
            wr_ptr_d[v] = wr_ptr_q[v] + PW'(push_w[v]);
            rd_ptr_d[v] = rd_ptr_q[v] + PW'(pop_w[v]);
        end
    end

    always_comb begin
        out_data_w = '0;
        count_w    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (!empty_w[v])
                out_data_w[v*DATA_WIDTH +: DATA_WIDTH] = mem_q[v][rd_ptr_q[v][ADDR_WIDTH-1:0]];
            count_w[v*PW +: PW] = cnt_w[v];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
            end
        end
    end

    // Storage is deliberately unreset; empty pointers mask stale contents.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_w[v]) mem_q[v][wr_ptr_q[v][ADDR_WIDTH-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = ~empty_w;
    assign bus.out_data  = out_data_w;
    assign bus.full      = full_w;
    assign bus.afull     = afull_w;
    assign bus.count     = count_w;

`ifdef VC_FIFO_ERR_EN
    logic [NUM_VC-1:0] err_ovf_q, err_ovf_d;
    logic [NUM_VC-1:0] err_udf_q, err_udf_d;
    logic [NUM_VC-1:0] set_ovf_w, set_udf_w;

    // A set in the same cycle as err_clr must survive, so clear first and OR the set on top.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            set_ovf_w[v] = bus.in_valid && (bus.in_vc == VC_W'(v)) && full_w[v];
            set_udf_w[v] = bus.out_ready[v] && empty_w[v];
        end
        set_ovf_w[0] = set_ovf_w[0] || (bus.in_valid && !vc_ok);
        err_ovf_d    = (bus.err_clr ? '0 : err_ovf_q) | set_ovf_w;
        err_udf_d    = (bus.err_clr ? '0 : err_udf_q) | set_udf_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= '0;
            err_udf_q <= '0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign bus.err_ovf = err_ovf_q;
    assign bus.err_udf = err_udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.err_ovf    = '0;
    assign bus.err_udf    = '0;
`endif
endmodule

// File: tb/tb_vc_fifo.sv
// Directed plus random bench for vc_fifo; per-VC queues model the buffer, checked each cycle.
module tb_vc_fifo;
    localparam int DW = 32, AW = 2, NV = 2, AF = 3, DEPTH = 4, PW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    vc_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV)) bus ();

    vc_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV), .AFULL_THRESH(AF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mq [NV][$];
    logic [NV-1:0] m_ovf = '0;
    logic [NV-1:0] m_udf = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] hd;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(mq[bus.in_vc].size() < DEPTH));
        for (int v = 0; v < NV; v++) begin
            hd = (mq[v].size() > 0) ? mq[v][0] : '0;
            chk($sformatf("%s.out_valid%0d", tag, v), 64'(bus.out_valid[v]), 64'(mq[v].size() > 0));
            chk($sformatf("%s.out_data%0d", tag, v), 64'(bus.out_data[v*DW +: DW]), 64'(hd));
            chk($sformatf("%s.count%0d", tag, v), 64'(bus.count[v*PW +: PW]), 64'(mq[v].size()));
            chk($sformatf("%s.full%0d", tag, v), 64'(bus.full[v]), 64'(mq[v].size() == DEPTH));
            chk($sformatf("%s.afull%0d", tag, v), 64'(bus.afull[v]), 64'(mq[v].size() >= AF));
            chk($sformatf("%s.err_ovf%0d", tag, v), 64'(bus.err_ovf[v]), 64'(m_ovf[v]));
            chk($sformatf("%s.err_udf%0d", tag, v), 64'(bus.err_udf[v]), 64'(m_udf[v]));
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) mq[v].delete();
        m_ovf = '0;
        m_udf = '0;
    endtask

    // Check current outputs against the queues, then advance the queues across one clock edge.
    task automatic step(input string tag);
        logic          acc;
        logic [NV-1:0] pop;
        int            wv;
        @(negedge clk);
        check_all(tag);
        wv  = int'(bus.in_vc);
        acc = bus.in_valid && (wv < NV) && (mq[wv].size() < DEPTH);
        for (int v = 0; v < NV; v++) pop[v] = bus.out_ready[v] && (mq[v].size() > 0);
`ifdef VC_FIFO_ERR_EN
        begin
            logic [NV-1:0] so, su;
            for (int v = 0; v < NV; v++) begin
                so[v] = bus.in_valid && (wv == v) && (mq[v].size() == DEPTH);
                su[v] = bus.out_ready[v] && (mq[v].size() == 0);
            end
            if (bus.in_valid && wv >= NV) so[0] = 1'b1;
            m_ovf = (bus.err_clr ? '0 : m_ovf) | so;
            m_udf = (bus.err_clr ? '0 : m_udf) | su;
        end
`endif
        @(posedge clk);
        for (int v = 0; v < NV; v++) if (pop[v]) void'(mq[v].pop_front());
        if (acc) mq[wv].push_back(bus.in_data);
        #1;
    endtask

    task automatic drive(input logic vld, input int vc, input logic [DW-1:0] d,
                         input logic [NV-1:0] rdy, input logic clr);
        bus.in_valid  = vld;
        bus.in_vc     = vc[0:0];
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.err_clr   = clr;
    endtask

    initial begin
        drive(1'b0, 0, '0, '0, 1'b0);
        model_reset();
        #1;
        check_all("in_reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // single write into VC1, head visible the next cycle
        drive(1'b1, 1, 32'hA5A5A5A5, 2'b00, 1'b0); step("wr_vc1");
        drive(1'b0, 0, '0, 2'b00, 1'b0);           step("vc1_head");
        chk("vc1_head.out_valid_vec", 64'(bus.out_valid), 64'h2);

        // fill VC0, overflow attempt, VC1 still open
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 0, 32'(i), 2'b00, 1'b0); step($sformatf("fill0_%0d", i));
        end
        drive(1'b1, 0, 32'h99, 2'b00, 1'b0);        step("ovf0");
        drive(1'b1, 1, 32'h11, 2'b00, 1'b0);        step("wr_vc1_b");

        // full VC0: same-cycle write+pop -> write rejected; then both accepted
        drive(1'b1, 0, 32'h44, 2'b01, 1'b0);        step("full_wp");
        drive(1'b1, 0, 32'h55, 2'b01, 1'b0);        step("wp_ok");
        drive(1'b0, 0, '0, 2'b00, 1'b0);            step("wp_chk");
        chk("wp_chk.count0", 64'(bus.count[2:0]), 64'd3);

        // drain everything
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, '0, 2'b11, 1'b0); step($sformatf("drain_%0d", i));
        end

        // streaming through VC1 across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1, 32'(i), 2'b10, 1'b0); step($sformatf("stream_%0d", i));
            chk($sformatf("stream_%0d.cnt_le1", i), 64'(bus.count[5:3] <= 3'd1), 64'd1);
        end
        drive(1'b0, 0, '0, 2'b10, 1'b0);            step("stream_tail");

        // two flits in each VC, then asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i % 2, 32'h100 + 32'(i), 2'b00, 1'b0); step($sformatf("pre_rst_%0d", i));
        end
        drive(1'b0, 0, '0, 2'b00, 1'b0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("rst_mid");
        chk("rst_mid.out_valid_vec", 64'(bus.out_valid), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 0, 32'hBEEF, 2'b00, 1'b0);      step("post_rst_wr");
        drive(1'b0, 0, '0, 2'b00, 1'b0);            step("post_rst_head");

        // underflow flag, clear, and clear colliding with a new underflow
        drive(1'b0, 0, '0, 2'b01, 1'b0);            step("udf_pop_head");
        drive(1'b0, 0, '0, 2'b01, 1'b0);            step("udf_set");
        drive(1'b0, 0, '0, 2'b00, 1'b0);            step("udf_hold");
        drive(1'b0, 0, '0, 2'b00, 1'b1);            step("udf_clr");
        drive(1'b0, 0, '0, 2'b00, 1'b0);            step("udf_cleared");
        drive(1'b0, 0, '0, 2'b01, 1'b1);            step("udf_clr_collide");
        drive(1'b0, 0, '0, 2'b00, 1'b0);            step("udf_after_collide");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)), $urandom,
                  2'($urandom), ($urandom_range(0, 15) == 0));
            step($sformatf("rnd_%0d", i));
        end
        drive(1'b0, 0, '0, 2'b00, 1'b0);            step("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
Multi-channel (virtual-channel) input buffer for a mesh router port. It holds NUM_VC independent circular FIFOs, each 2^ADDR_WIDTH entries deep. A single shared write port is steered by a VC tag. Each VC has its own first-word-fall-through read port with a valid/ready handshake, plus per-VC occupancy and almost-full status for credit and flow control.

Parameters:
- DATA_WIDTH, 32, flit width in bits
- ADDR_WIDTH, 2, log2 of per-VC depth (DEPTH = 2^ADDR_WIDTH, ADDR_WIDTH >= 1)
- NUM_VC, 2, number of virtual channels (>= 1)
- AFULL_THRESH, 3, per-VC occupancy at or above which afull asserts (1..DEPTH)
- localparam VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  write request
- in_vc  in  VC_W  target VC of write
- in_data  in  DATA_WIDTH  write flit
- in_ready  out  1  write accepted this cycle if in_valid
- out_valid  out  NUM_VC  bit v: VC v non-empty
- out_data  out  NUM_VC*DATA_WIDTH  slice v = head flit of VC v
- out_ready  in  NUM_VC  bit v: consumer pops VC v
- full  out  NUM_VC  per-VC full
- afull  out  NUM_VC  per-VC almost full
- count  out  NUM_VC*(ADDR_WIDTH+1)  slice v = occupancy of VC v, 0..DEPTH
- err_clr  in  1  clears sticky error flags (optional feature)
- err_ovf  out  NUM_VC  sticky write-when-full / bad-VC flag
- err_udf  out  NUM_VC  sticky pop-when-empty flag

Behaviour:
- Reset (asynchronous on rst high) clears all wr/rd pointers, which are ADDR_WIDTH+1 bits with a wrap bit. While in reset and immediately after it, every output is 0 except in_ready, which follows the rule below.
- Memory contents are not reset.
- full[v]: MSBs of the wr/rd pointers differ and the low bits are equal. Empty: pointers are equal. count[v] = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- afull[v] = (count[v] >= AFULL_THRESH). This is combinational from the registered pointers.
- in_ready = (in_vc < NUM_VC) && !full[in_vc]. It is purely combinational and never depends on out_ready.
- Write: when in_valid && in_ready at a clock edge, in_data goes to mem[in_vc][wr_ptr low bits] and wr_ptr[in_vc] increments.
- Writes with in_valid && !in_ready are dropped. The sender is responsible for not issuing them.
- Read is FWFT:
  - out_valid[v] = !empty[v].
  - The out_data slice v is driven combinationally from mem[v][rd_ptr low bits] when out_valid[v] is 1, and is forced to 0 when out_valid[v] is 0.
  - A pop occurs when out_valid[v] && out_ready[v] at a clock edge; rd_ptr[v] then increments. out_ready[v] with an empty VC has no effect.
- Latency: a write into an empty VC gives out_valid = 1 and the correct out_data on the cycle after the edge. There is no bypass from in_data.
- Same VC, same cycle, write and pop:
  - Both take effect if individually legal, and count is unchanged.
  - Full VC: the write is rejected, because in_ready is evaluated before the pop. The pop proceeds and count drops by 1.
  - Empty VC: the pop is ignored and the write proceeds.
- Different VCs: a write to one VC and pops on any set of VCs all proceed in the same cycle.
- Wrap-around: pointers roll over naturally. The MSB toggles on every DEPTH increments.
- Reset mid-operation: all VCs are emptied immediately. Stored flits are lost, not replayed.

Optional Feature:
Macro: VC_FIFO_ERR_EN
- Defined:
  - err_ovf[v] sets on in_valid with in_vc == v and full[v].
  - err_ovf[0] also sets on in_valid with in_vc >= NUM_VC.
  - err_udf[v] sets on out_ready[v] with VC v empty.
  - Flags are sticky. They are cleared to 0 by err_clr; a set in the same cycle as err_clr wins. rst clears them.
- Not defined: err_ovf and err_udf are tied to 0, err_clr is ignored, and no flag registers are synthesised.

Test Plan:
- Reset, then a single write of in_vc=1, data 0xA5A5A5A5 → next cycle out_valid=2'b10, out_data[63:32]=0xA5A5A5A5, count[5:3]=1. VC0 stays empty with out_data[31:0]=0.
- Fill VC0 with 4 flits (0..3) → full[0]=1, afull[0]=1 after the 3rd write, in_ready=0 for in_vc=0. A 5th write is dropped; with VC_FIFO_ERR_EN, err_ovf[0]=1. VC1 writes are still accepted.
- VC0 full, then write plus pop on VC0 in the same cycle → head 0 popped, write rejected, count[0]=3. Next cycle write+pop → accepted, count stays 3.
- Stream 10 flits through VC1 with out_ready[1] held high → flits pop in order 0..9 across pointer wrap, count never exceeds 1, and no errors.
- Assert rst for one cycle while both VCs hold 2 flits → out_valid=0, count=0, full=0 immediately. The next write appears after 1 cycle.
- With VC_FIFO_ERR_EN: out_ready[0]=1 on an empty VC → err_udf[0]=1 and holds. err_clr pulse → 0. err_clr in the same cycle as a new underflow → stays 1.
